// File: rtl/exec_alu_branch_decode_if.sv
// Data-side bus of the execute stage: memory and IO request channels plus the IO-select flag.
// The master (execute stage) drives requests; the slave (memory/IO fabric) receives them.
interface exec_alu_branch_decode_if;
  logic [31:0] mem_address;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_write_value;
  logic [2:0]  mem_data_size;
  logic [31:0] io_address;
  logic        io_read_en;
  logic        io_write_en;
  logic [31:0] io_write_value;
  logic [2:0]  io_data_size;
  logic        is_io;

  modport master (
    output mem_address, mem_read_en, mem_write_en, mem_write_value, mem_data_size,
    output io_address, io_read_en, io_write_en, io_write_value, io_data_size, is_io
  );

  modport slave (
    input mem_address, mem_read_en, mem_write_en, mem_write_value, mem_data_size,
    input io_address, io_read_en, io_write_en, io_write_value, io_data_size, is_io
  );
endinterface

// File: rtl/exec_alu_branch_decode.sv
// Execute stage: 32-bit ALU, branch comparator and load/store address decoder (memory vs IO).
// Define ALU_MUL_EN to enable MUL/MULH/MULHU on alu_op 11-13.
module exec_alu_branch_decode #(
  parameter logic [31:0] IO_BASE = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [3:0]  alu_op,
  output logic [31:0] alu_out,
  output logic        alu_zero,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [2:0]  branch_cond,
  output logic        branch,
  input  logic        data_read_en,
  input  logic        data_write_en,
  input  logic [2:0]  data_size,
  exec_alu_branch_decode_if.master dbus,
  output logic        misaligned,
  output logic        misalign_err
);

  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic        cmp_eq;
  logic        cmp_lt;
  logic        cmp_ltu;
  logic        access;
  logic        misalign_err_reg;

  assign shamt = alu_b[4:0];

`ifdef ALU_MUL_EN
  logic [63:0] mul_ss;
  logic [31:0] mulhu;
  assign mul_ss = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
  // Unsigned high half recovered from the signed product, so only one multiplier is built.
  assign mulhu  = mul_ss[63:32] + (alu_a[31] ? alu_b : 32'd0) + (alu_b[31] ? alu_a : 32'd0);
`endif

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a << shamt;
      4'd3:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd4:    alu_result = {31'd0, alu_a < alu_b};
      4'd5:    alu_result = alu_a ^ alu_b;
      4'd6:    alu_result = alu_a >> shamt;
      4'd7:    alu_result = $signed(alu_a) >>> shamt;
      4'd8:    alu_result = alu_a | alu_b;
      4'd9:    alu_result = alu_a & alu_b;
      4'd10:   alu_result = alu_b;
`ifdef ALU_MUL_EN
      4'd11:   alu_result = mul_ss[31:0];
      4'd12:   alu_result = mul_ss[63:32];
      4'd13:   alu_result = mulhu;
`endif
      default: alu_result = '0;
    endcase
  end

  assign alu_out  = alu_result;
  assign alu_zero = (alu_result == 32'd0);

  assign cmp_eq  = (rs1_value == rs2_value);
  assign cmp_lt  = ($signed(rs1_value) < $signed(rs2_value));
  assign cmp_ltu = (rs1_value < rs2_value);

  always_comb begin
    branch = 1'b0;
    case (branch_cond)
      3'd0: branch = 1'b0;
      3'd1: branch = 1'b1;
      3'd2: branch = cmp_eq;
      3'd3: branch = !cmp_eq;
      3'd4: branch = cmp_lt;
      3'd5: branch = !cmp_lt;
      3'd6: branch = cmp_ltu;
      3'd7: branch = !cmp_ltu;
      default: branch = 1'b0;
    endcase
  end

  // Alignment only depends on size[1:0]; signed and unsigned variants share the rule.
  assign access     = data_read_en | data_write_en;
  assign misaligned = access & (((data_size[1:0] == 2'b01) & alu_result[0]) |
                                ((data_size[1:0] == 2'b10) & (alu_result[1:0] != 2'b00)));

  assign dbus.is_io           = (alu_result >= IO_BASE);
  assign dbus.mem_address     = alu_result;
  assign dbus.io_address      = alu_result;
  assign dbus.mem_write_value = rs2_value;
  assign dbus.io_write_value  = rs2_value;
  assign dbus.mem_data_size   = data_size;
  assign dbus.io_data_size    = data_size;
  assign dbus.mem_read_en     = data_read_en  & !dbus.is_io & !misaligned;
  assign dbus.mem_write_en    = data_write_en & !dbus.is_io & !misaligned;
  assign dbus.io_read_en      = data_read_en  &  dbus.is_io & !misaligned;
  assign dbus.io_write_en     = data_write_en &  dbus.is_io & !misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err_reg <= 1'b0;
    end else if (misaligned) begin
      misalign_err_reg <= 1'b1;
    end
  end

  assign misalign_err = misalign_err_reg;

endmodule

// File: tb/tb_exec_alu_branch_decode.sv
// Randomized scoreboard bench for exec_alu_branch_decode against a behavioural reference model.
module tb_exec_alu_branch_decode;
  localparam logic [31:0] IO_BASE = 32'h0000_8000;

  typedef struct {
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        branch;
    logic        is_io;
    logic        misaligned;
    logic        misalign_err;
    logic        mem_rd, mem_wr, io_rd, io_wr;
    logic [31:0] wval;
    logic [2:0]  size;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] alu_a = '0, alu_b = '0, rs1_value = '0, rs2_value = '0;
  logic [3:0]  alu_op = '0;
  logic [2:0]  branch_cond = '0, data_size = '0;
  logic        data_read_en = 1'b0, data_write_en = 1'b0;
  logic [31:0] alu_out;
  logic        alu_zero, branch, misaligned, misalign_err;

  exec_alu_branch_decode_if bus_if();

  exec_alu_branch_decode #(.IO_BASE(IO_BASE)) dut (
    .clk(clk), .reset(reset),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .branch_cond(branch_cond), .branch(branch),
    .data_read_en(data_read_en), .data_write_en(data_write_en), .data_size(data_size),
    .dbus(bus_if.master),
    .misaligned(misaligned), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  logic err_model = 1'b0;

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    int unsigned sh = b % 32;
    longint      ps;
    logic [63:0] pu;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      8: return a | b;
      9: return a & b;
      10: return b;
`ifdef ALU_MUL_EN
      11: return ps[31:0];
      12: return ps[63:32];
      13: return pu[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_branch(logic [31:0] x, logic [31:0] y, logic [2:0] c);
    case (c)
      0: return 1'b0;
      1: return 1'b1;
      2: return x == y;
      3: return x != y;
      4: return int'(x) < int'(y);
      5: return int'(x) >= int'(y);
      6: return x < y;
      default: return x >= y;
    endcase
  endfunction

  task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s txn %0d: got %h, expected %h", name, id, act, exp);
    end
  endtask

  task automatic go(logic [31:0] a, logic [31:0] b, logic [3:0] op,
                    logic [31:0] r1, logic [31:0] r2, logic [2:0] cond,
                    logic rd, logic wr, logic [2:0] sz, logic rst);
    exp_t e;
    logic acc;
    @(posedge clk);
    #1;
    alu_a = a; alu_b = b; alu_op = op; rs1_value = r1; rs2_value = r2;
    branch_cond = cond; data_read_en = rd; data_write_en = wr; data_size = sz; reset = rst;
    e.id = n_txn++;
    e.alu_out = ref_alu(a, b, op);
    e.alu_zero = (e.alu_out == 0);
    e.branch = ref_branch(r1, r2, cond);
    e.is_io = (e.alu_out >= IO_BASE);
    acc = rd || wr;
    e.misaligned = acc && ((sz[1:0] == 2'b01 && e.alu_out % 2 != 0) ||
                           (sz[1:0] == 2'b10 && e.alu_out % 4 != 0));
    e.mem_rd = rd && !e.is_io && !e.misaligned;
    e.mem_wr = wr && !e.is_io && !e.misaligned;
    e.io_rd  = rd && e.is_io && !e.misaligned;
    e.io_wr  = wr && e.is_io && !e.misaligned;
    e.wval = r2;
    e.size = sz;
    e.misalign_err = err_model;
    q.push_back(e);
    err_model = rst ? 1'b0 : (err_model | e.misaligned);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        $display("txn %0d op=%0d a=%h b=%h out=%h br=%b io=%b mis=%b err=%b",
                 e.id, alu_op, alu_a, alu_b, alu_out, branch, bus_if.is_io, misaligned, misalign_err);
        chk("alu_out", e.id, alu_out, e.alu_out);
        chk("alu_zero", e.id, 32'(alu_zero), 32'(e.alu_zero));
        chk("branch", e.id, 32'(branch), 32'(e.branch));
        chk("is_io", e.id, 32'(bus_if.is_io), 32'(e.is_io));
        chk("misaligned", e.id, 32'(misaligned), 32'(e.misaligned));
        chk("misalign_err", e.id, 32'(misalign_err), 32'(e.misalign_err));
        chk("enables", e.id,
            {28'd0, bus_if.mem_read_en, bus_if.mem_write_en, bus_if.io_read_en, bus_if.io_write_en},
            {28'd0, e.mem_rd, e.mem_wr, e.io_rd, e.io_wr});
        chk("mem_address", e.id, bus_if.mem_address, e.alu_out);
        chk("io_address", e.id, bus_if.io_address, e.alu_out);
        chk("mem_write_value", e.id, bus_if.mem_write_value, e.wval);
        chk("io_write_value", e.id, bus_if.io_write_value, e.wval);
        chk("data_size", e.id, {26'd0, bus_if.mem_data_size, bus_if.io_data_size}, {26'd0, e.size, e.size});
      end
    end
  end

  initial begin : driver
    logic [2:0] sizes [5];
    sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset = 1'b1;
    repeat (2) @(posedge clk);
    // Directed vectors from the block's expected behaviour.
    go(32'd7, 32'd9, 4'd1, 32'd5, 32'd5, 3'd2, 0, 0, 3'b010, 0);
    go(32'hFFFF_FFFF, 32'd1, 4'd3, 32'd5, 32'd5, 3'd3, 0, 0, 3'b010, 0);
    go(32'hFFFF_FFFF, 32'd1, 4'd4, 32'hFFFF_FFFF, 32'd1, 3'd4, 0, 0, 3'b010, 0);
    go(32'h8000_0000, 32'd4, 4'd7, 32'hFFFF_FFFF, 32'd1, 3'd6, 0, 0, 3'b010, 0);
    go(32'd0, 32'd0, 4'd0, 32'd1, 32'd2, 3'd0, 0, 0, 3'b000, 0);
    go(32'd0, 32'd0, 4'd0, 32'd1, 32'd2, 3'd1, 0, 0, 3'b000, 0);
    go(32'h100, 32'd0, 4'd0, 32'd0, 32'hDEAD_BEEF, 3'd0, 0, 1, 3'b010, 0);
    go(32'h8000, 32'd4, 4'd0, 32'd0, 32'd0, 3'd0, 1, 0, 3'b010, 0);
    go(32'h8000, 32'd4, 4'd0, 32'd0, 32'd0, 3'd0, 0, 0, 3'b010, 0);
    go(32'h7FFC, 32'd0, 4'd0, 32'd0, 32'd0, 3'd0, 1, 0, 3'b010, 0);
    go(32'h8000, 32'd0, 4'd10, 32'd0, 32'd0, 3'd0, 1, 1, 3'b000, 0);
    go(32'hFFFF_FFFF, 32'd2, 4'd11, 32'd0, 32'd0, 3'd0, 0, 0, 3'b000, 0);
    go(32'hFFFF_FFFF, 32'd2, 4'd12, 32'd0, 32'd0, 3'd0, 0, 0, 3'b000, 0);
    go(32'hFFFF_FFFF, 32'd2, 4'd13, 32'd0, 32'd0, 3'd0, 0, 0, 3'b000, 0);
    go(32'h100, 32'd2, 4'd0, 32'd0, 32'd0, 3'd0, 1, 0, 3'b010, 0);
    go(32'h100, 32'd0, 4'd0, 32'd0, 32'd0, 3'd0, 1, 0, 3'b010, 0);
    go(32'h101, 32'd0, 4'd0, 32'd0, 32'd0, 3'd0, 1, 0, 3'b000, 0);
    go(32'h100, 32'd0, 4'd0, 32'd0, 32'd0, 3'd0, 0, 1, 3'b001, 1);
    go(32'h100, 32'd0, 4'd0, 32'd0, 32'd0, 3'd0, 0, 1, 3'b101, 0);
    go(32'h8001, 32'd0, 4'd0, 32'd0, 32'd0, 3'd0, 0, 1, 3'b001, 0);
    go(32'h8001, 32'd0, 4'd0, 32'd0, 32'd0, 3'd0, 0, 1, 3'b001, 1);
    go(32'h8000, 32'd0, 4'd0, 32'd0, 32'd0, 3'd0, 0, 1, 3'b010, 0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb, r1, r2;
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        ra = IO_BASE + $urandom_range(0, 16) - 8;
        rb = $urandom_range(0, 3);
      end
      r1 = $urandom();
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom();
      go(ra, rb, 4'($urandom_range(0, 15)), r1, r2, 3'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         sizes[$urandom_range(0, 4)], ($urandom_range(0, 19) == 0));
    end
    repeat (2) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
